// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle ops plus iterative MUL and DIV/REM behind valid/ready handshakes.
// Define ALU_MC_FAST_MUL_EN to replace the iterative multiplier with a combinational one.
module alu_mc #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] r1,
  input  logic [WIDTH-1:0] r2,
  input  logic [7:0]       alu_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  localparam logic [7:0] OP_ADD   = 8'd0;
  localparam logic [7:0] OP_SUB   = 8'd1;
  localparam logic [7:0] OP_AND   = 8'd2;
  localparam logic [7:0] OP_OR    = 8'd3;
  localparam logic [7:0] OP_XOR   = 8'd4;
  localparam logic [7:0] OP_SLT   = 8'd5;
  localparam logic [7:0] OP_SLTU  = 8'd6;
  localparam logic [7:0] OP_SRA   = 8'd7;
  localparam logic [7:0] OP_SRL   = 8'd8;
  localparam logic [7:0] OP_SLL   = 8'd9;
  localparam logic [7:0] OP_MUL   = 8'd10;
  localparam logic [7:0] OP_LUI   = 8'd11;
  localparam logic [7:0] OP_AUIPC = 8'd12;
  localparam logic [7:0] OP_LW    = 8'd13;
  localparam logic [7:0] OP_SW    = 8'd14;
  localparam logic [7:0] OP_JAL   = 8'd15;
  localparam logic [7:0] OP_JR    = 8'd16;
  localparam logic [7:0] OP_JALR  = 8'd17;
  localparam logic [7:0] OP_BEQ   = 8'd18;
  localparam logic [7:0] OP_BNE   = 8'd19;
  localparam logic [7:0] OP_BLT   = 8'd20;
  localparam logic [7:0] OP_BGE   = 8'd21;
  localparam logic [7:0] OP_BLTU  = 8'd22;
  localparam logic [7:0] OP_BGEU  = 8'd23;
  localparam logic [7:0] OP_DIV   = 8'd24;
  localparam logic [7:0] OP_DIVU  = 8'd25;
  localparam logic [7:0] OP_REM   = 8'd26;
  localparam logic [7:0] OP_REMU  = 8'd27;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t           state_q, state_d;
  logic             alive_q;
  logic [7:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic [WIDTH-1:0] result_q, result_d;

  // Operand decode for the single-cycle path
  logic [SHW-1:0]          shamt;
  logic signed [WIDTH-1:0] r1_s;
  logic [WIDTH-1:0]        sra_res;
  logic [WIDTH-1:0]        min_neg;
  logic                    lt_s, lt_u, eq;
  logic                    div_zero, div_ovf, is_div_op, div_signed_in;
  logic                    div_iter, mul_iter;
  logic [WIDTH-1:0]        r1_mag, r2_mag;
  logic [WIDTH-1:0]        single_res;

  assign shamt         = r2[SHW-1:0];
  assign r1_s          = r1;
  assign sra_res       = r1_s >>> shamt;
  assign min_neg       = {1'b1, {(WIDTH-1){1'b0}}};
  assign lt_s          = $signed(r1) < $signed(r2);
  assign lt_u          = r1 < r2;
  assign eq            = r1 == r2;
  assign div_zero      = r2 == '0;
  assign div_ovf       = (r1 == min_neg) && (r2 == '1);
  assign is_div_op     = (alu_control >= OP_DIV) && (alu_control <= OP_REMU);
  assign div_signed_in = (alu_control == OP_DIV) || (alu_control == OP_REM);
  assign div_iter      = is_div_op && !div_zero && !(div_signed_in && div_ovf);
  assign r1_mag        = (div_signed_in && r1[WIDTH-1]) ? -r1 : r1;
  assign r2_mag        = (div_signed_in && r2[WIDTH-1]) ? -r2 : r2;
`ifdef ALU_MC_FAST_MUL_EN
  assign mul_iter      = 1'b0;
`else
  assign mul_iter      = alu_control == OP_MUL;
`endif

  always_comb begin
    single_res = '0;
    case (alu_control)
      OP_ADD, OP_LW, OP_SW, OP_JAL, OP_JR, OP_JALR: single_res = r1 + r2;
      OP_SUB:           single_res = r1 - r2;
      OP_AND:           single_res = r1 & r2;
      OP_OR:            single_res = r1 | r2;
      OP_XOR:           single_res = r1 ^ r2;
      OP_SLT, OP_BLT:   single_res = WIDTH'(lt_s);
      OP_SLTU, OP_BLTU: single_res = WIDTH'(lt_u);
      OP_BGE:           single_res = WIDTH'(!lt_s);
      OP_BGEU:          single_res = WIDTH'(!lt_u);
      OP_BEQ:           single_res = WIDTH'(eq);
      OP_BNE:           single_res = WIDTH'(!eq);
      OP_SRA:           single_res = sra_res;
      OP_SRL:           single_res = r1 >> shamt;
      OP_SLL:           single_res = r1 << shamt;
      OP_LUI:           single_res = r2 << 12;
      OP_AUIPC:         single_res = r1 + (r2 << 12);
`ifdef ALU_MC_FAST_MUL_EN
      OP_MUL:           single_res = r1 * r2;
`endif
      // Only the divide corner cases ever take this path
      OP_DIV:           single_res = div_zero ? '1 : (div_ovf ? r1 : '0);
      OP_DIVU:          single_res = div_zero ? '1 : '0;
      OP_REM, OP_REMU:  single_res = div_zero ? r1 : '0;
      default:          single_res = '0;
    endcase
  end

  // Iteration datapath: a/b hold multiplicand/multiplier or dividend-quotient/divisor
  logic [WIDTH-1:0] mul_sum;
  logic [WIDTH:0]   div_diff;
  logic [WIDTH-1:0] quo_new, rem_new, quo_fix, rem_fix;
  logic             last;

  assign mul_sum  = acc_q + (b_q[0] ? a_q : '0);
  assign div_diff = {acc_q, a_q[WIDTH-1]} - {1'b0, b_q};
  assign quo_new  = {a_q[WIDTH-2:0], ~div_diff[WIDTH]};
  assign rem_new  = div_diff[WIDTH] ? {acc_q[WIDTH-2:0], a_q[WIDTH-1]} : div_diff[WIDTH-1:0];
  assign quo_fix  = qneg_q ? -quo_new : quo_new;
  assign rem_fix  = rneg_q ? -rem_new : rem_new;
  assign last     = cnt_q == SHW'(WIDTH-1);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          op_d   = alu_control;
          cnt_d  = '0;
          acc_d  = '0;
          qneg_d = div_signed_in && (r1[WIDTH-1] ^ r2[WIDTH-1]);
          rneg_d = div_signed_in && r1[WIDTH-1];
          if (mul_iter) begin
            a_d     = r1;
            b_d     = r2;
            state_d = S_MUL;
          end else if (div_iter) begin
            a_d     = r1_mag;
            b_d     = r2_mag;
            state_d = S_DIV;
          end else begin
            result_d = single_res;
            state_d  = S_DONE;
          end
        end
      end
      S_MUL: begin
        acc_d = mul_sum;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + SHW'(1);
        if (last) begin
          result_d = mul_sum;
          state_d  = S_DONE;
        end
      end
      S_DIV: begin
        acc_d = rem_new;
        a_d   = quo_new;
        cnt_d = cnt_q + SHW'(1);
        if (last) begin
          result_d = ((op_q == OP_DIV) || (op_q == OP_DIVU)) ? quo_fix : rem_fix;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      alive_q  <= 1'b0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      alive_q  <= 1'b1;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
    end
  end

  // alive_q keeps in_ready low until the first edge after reset release
  assign in_ready  = alive_q && (state_q == S_IDLE);
  assign out_valid = state_q == S_DONE;
  assign busy      = (state_q == S_MUL) || (state_q == S_DIV);
  assign result    = result_q;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: vector table plus handshake, flush and reset sequences.
module tb_alu_mc;
  localparam int W = 32;
`ifdef ALU_MC_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] r1 = '0;
  logic [W-1:0] r2 = '0;
  logic [7:0]   alu_control = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         busy;

  alu_mc #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .r1(r1), .r2(r2), .alu_control(alu_control), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
    int           lat;
  } vec_t;

  vec_t         vecs[$];
  logic [W-1:0] sb_q[$];
  int           total = 0;
  int           bad = 0;

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic void add(input logic [7:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W-1:0] e, input int lat);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.exp = e; v.lat = lat;
    vecs.push_back(v);
  endfunction

  // Drives one op; returns at the falling edge of the cycle after accept
  task automatic start_op(input logic [7:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] e);
    @(negedge clk);
    check("in_ready_before_accept", W'(in_ready), W'(1));
    in_valid = 1'b1; alu_control = op; r1 = a; r2 = b;
    @(posedge clk);
    sb_q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0; r1 = $urandom; r2 = $urandom; alu_control = 8'($urandom);
  endtask

  task automatic wait_result(input string nm, input int lat);
    int cyc;
    logic [W-1:0] e;
    cyc = 1;
    while (!out_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check({nm, "_latency"}, W'(cyc), W'(lat));
    if (sb_q.size() == 0) begin
      bad++; total++;
      $display("FAIL %s_scoreboard: got result %h expected none pending", nm, result);
    end else begin
      e = sb_q.pop_front();
      check({nm, "_result"}, result, e);
    end
    $display("txn %s result=%h latency=%0d", nm, result, cyc);
  endtask

  task automatic finish_handshake(input string nm);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({nm, "_in_ready_after"}, W'(in_ready), W'(1));
    check({nm, "_out_valid_after"}, W'(out_valid), W'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int vcnt;
    // Vector table
    add(8'd0,  32'd5,        32'd7,        32'd12,         1);
    add(8'd1,  32'd5,        32'd7,        32'hFFFFFFFE,   1);
    add(8'd2,  32'hF0F0,     32'hFF00,     32'hF000,       1);
    add(8'd3,  32'hF0F0,     32'h0F00,     32'hFFF0,       1);
    add(8'd4,  32'hFF,       32'h0F,       32'hF0,         1);
    add(8'd5,  32'hFFFFFFFF, 32'd1,        32'd1,          1);
    add(8'd6,  32'hFFFFFFFF, 32'd1,        32'd0,          1);
    add(8'd7,  32'h80000000, 32'd4,        32'hF8000000,   1);
    add(8'd8,  32'h80000000, 32'd4,        32'h08000000,   1);
    add(8'd9,  32'd1,        32'h21,       32'd2,          1);
    add(8'd11, 32'hDEAD,     32'h12345,    32'h12345000,   1);
    add(8'd12, 32'h100,      32'd1,        32'h1100,       1);
    add(8'd13, 32'd3,        32'd4,        32'd7,          1);
    add(8'd17, 32'hFFFFFFFF, 32'd1,        32'd0,          1);
    add(8'd18, 32'd5,        32'd5,        32'd1,          1);
    add(8'd19, 32'd5,        32'd5,        32'd0,          1);
    add(8'd20, 32'h80000000, 32'd0,        32'd1,          1);
    add(8'd21, 32'h80000000, 32'd0,        32'd0,          1);
    add(8'd22, 32'h80000000, 32'd0,        32'd0,          1);
    add(8'd28, 32'd5,        32'd7,        32'd0,          1);
    add(8'd255,32'd5,        32'd7,        32'd0,          1);
    add(8'd10, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFEB,   MUL_LAT);
    add(8'd10, 32'h10000,    32'h10000,    32'd0,          MUL_LAT);
    add(8'd10, 32'd12345,    32'd678,      32'd8369910,    MUL_LAT);
    add(8'd24, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD,   33);
    add(8'd26, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF,   33);
    add(8'd25, 32'd100,      32'd7,        32'd14,         33);
    add(8'd27, 32'd100,      32'd7,        32'd2,          33);
    add(8'd24, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD,   33);
    add(8'd26, 32'd7,        32'hFFFFFFFE, 32'd1,          33);
    add(8'd25, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF,   33);
    add(8'd25, 32'h80000000, 32'hFFFFFFFF, 32'd0,          33);
    add(8'd27, 32'h80000000, 32'hFFFFFFFF, 32'h80000000,   33);
    add(8'd24, 32'd10,       32'd0,        32'hFFFFFFFF,   1);
    add(8'd26, 32'd10,       32'd0,        32'd10,         1);
    add(8'd25, 32'd5,        32'd0,        32'hFFFFFFFF,   1);
    add(8'd27, 32'd5,        32'd0,        32'd5,          1);
    add(8'd24, 32'h80000000, 32'hFFFFFFFF, 32'h80000000,   1);
    add(8'd26, 32'h80000000, 32'hFFFFFFFF, 32'd0,          1);

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_in_ready", W'(in_ready), W'(0));
    check("reset_out_valid", W'(out_valid), W'(0));
    check("reset_busy", W'(busy), W'(0));
    check("reset_result", result, W'(0));
    rst_n = 1'b1;
    #1;
    check("release_in_ready_no_edge", W'(in_ready), W'(0));
    @(negedge clk);
    check("release_in_ready_after_edge", W'(in_ready), W'(1));

    // Table-driven pass
    vcnt = 0;
    foreach (vecs[i]) begin
      start_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
      check($sformatf("v%0d_busy", vcnt), W'(busy), W'(vecs[i].lat > 1));
      wait_result($sformatf("v%0d_op%0d", vcnt, vecs[i].op), vecs[i].lat);
      finish_handshake($sformatf("v%0d", vcnt));
      vcnt++;
    end

    // Back-pressure: result held, in_ready low, pulsed in_valid ignored
    start_op(8'd23, 32'd3, 32'd3, 32'd1);
    wait_result("bgeu_hold", 1);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("hold%0d_out_valid", k), W'(out_valid), W'(1));
      check($sformatf("hold%0d_result", k), result, W'(1));
      check($sformatf("hold%0d_in_ready", k), W'(in_ready), W'(0));
      if (k == 1) begin
        in_valid = 1'b1; alu_control = 8'd0; r1 = 32'd40; r2 = 32'd2;
      end
      if (k == 2) in_valid = 1'b0;
      @(negedge clk);
    end
    finish_handshake("bgeu_hold");
    begin
      int seen;
      seen = 0;
      repeat (4) begin
        @(negedge clk);
        if (out_valid) seen++;
      end
      check("ignored_pulse_no_output", W'(seen), W'(0));
    end

    // Flush in cycle 10 of a DIV
    start_op(8'd25, 32'd100, 32'd7, 32'd14);
    repeat (8) @(negedge clk);
    check("flush_busy_before", W'(busy), W'(1));
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    void'(sb_q.pop_front());
    check("flush_in_ready", W'(in_ready), W'(1));
    check("flush_busy", W'(busy), W'(0));
    begin
      int seen;
      seen = 0;
      repeat (40) begin
        @(negedge clk);
        if (out_valid) seen++;
      end
      check("flush_no_out_valid", W'(seen), W'(0));
    end
    $display("txn flush_div discarded");

    // Leave a nonzero result registered, then reset mid-MUL
    start_op(8'd0, 32'd5, 32'd7, 32'd12);
    wait_result("add_before_reset", 1);
    finish_handshake("add_before_reset");
    start_op(8'd10, 32'd3, 32'd5, 32'd15);
    repeat (4) @(negedge clk);
    check("mul_busy_before_reset", W'(busy), W'(MUL_LAT > 1));
    #1 rst_n = 1'b0;
    #1;
    check("midreset_out_valid", W'(out_valid), W'(0));
    check("midreset_busy", W'(busy), W'(0));
    check("midreset_result", result, W'(0));
    check("midreset_in_ready", W'(in_ready), W'(0));
    void'(sb_q.pop_front());
    $display("txn mul_reset discarded");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_in_ready", W'(in_ready), W'(1));

    // Unit still works after reset
    start_op(8'd10, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFEB);
    wait_result("mul_after_reset", MUL_LAT);
    finish_handshake("mul_after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised multi-cycle ALU for the tiny RISC-V core; successor to the single-cycle combinational ALU.
- Keeps the existing 8-bit op encoding and adds the RV32M divide/remainder ops.
- Operands are accepted and results delivered over valid/ready handshakes, so the pipeline can stall on long operations.
- MUL and DIV/REM run as iterative state machines; every other op completes in one cycle.

Parameters:
- WIDTH, 32, datapath width; power of two, minimum 8.
- SHW, $clog2(WIDTH), shift-amount width; derived, do not override.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous abort of the current operation.
- in_valid  in  1  operands and op are valid this cycle.
- in_ready  out  1  unit can accept an operation.
- r1  in  WIDTH  operand 1, two's complement.
- r2  in  WIDTH  operand 2, two's complement.
- alu_control  in  8  opcode.
- out_valid  out  1  result is valid.
- out_ready  in  1  consumer takes the result.
- result  out  WIDTH  result value.
- busy  out  1  high in MUL or DIV state.

Behaviour:
- Opcodes: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLT 5, SLTU 6, SRA 7, SRL 8, SLL 9, MUL 10, LUI 11, AUIPC 12, LW 13, SW 14, JAL 15, JR 16, JALR 17, BEQ 18, BNE 19, BLT 20, BGE 21, BLTU 22, BGEU 23, DIV 24, DIVU 25, REM 26, REMU 27.
- Codes 13–17 compute r1+r2. Any other undefined code gives result 0 with 1-cycle latency.
- Shifts use r2[SHW-1:0]. SRA fills with r1[WIDTH-1].
- LUI = r2<<12. AUIPC = r1+(r2<<12). Both truncated to WIDTH.
- Compare ops return a result zero-extended from 1 bit. BGEU is unsigned r1>=r2.
- MUL returns the low WIDTH bits of the product.
- All arithmetic is modulo 2^WIDTH.
- States:
  - IDLE: in_ready=1. Handshake (in_valid & in_ready) latches the operands and op.
    - MUL goes to MUL state.
    - DIV* / REM* with nonzero divisor and no signed overflow goes to DIV state.
    - Everything else computes the result and goes to DONE.
  - MUL: shift-add, one multiplier bit per cycle, WIDTH cycles, then DONE.
  - DIV: restoring division on magnitudes, WIDTH cycles, sign fix-up applied on exit, then DONE.
    - Quotient is truncated toward zero.
    - Remainder takes the sign of the dividend.
  - DONE: out_valid=1, result held stable. When out_ready=1, go to IDLE.
- Latency from accept to out_valid:
  - 1 cycle for single-cycle ops.
  - WIDTH+1 cycles for MUL and DIV.
  - in_ready is low from the cycle after accept until the cycle after the result handshake. No back-to-back accepts.
- Divide corner cases, 1-cycle latency:
  - Divisor 0: DIV/DIVU give all ones; REM/REMU give r1.
  - DIV/REM with r1 = most negative and r2 = -1: DIV gives r1; REM gives 0.
- in_valid is ignored whenever in_ready=0.
- Operand inputs may change after accept without effect.
- flush=1 at a rising edge: next state IDLE, out_valid=0, any pending result is discarded. flush wins over a simultaneous in_valid or out_ready.
- Reset: rst_n low immediately forces IDLE and clears all registers.
  - Reset values: in_ready=0 while rst_n is low and 1 from the first edge after release; out_valid=0, result=0, busy=0.
  - Reset mid-operation discards the operation.

Optional Feature:
- ALU_MC_FAST_MUL_EN:
  - When defined, MUL uses a combinational WIDTH×WIDTH multiplier and behaves as a single-cycle op (1-cycle latency, MUL state unused).
  - When undefined, the iterative multiplier above applies (WIDTH+1 latency).
- Results are identical either way.

Test Plan:
1. ADD r1=5, r2=7 → out_valid 1 cycle after accept, result 12. SRA r1=0x80000000, r2=4 → 0xF8000000. SRL same operands → 0x08000000.
2. MUL r1=0xFFFFFFFD, r2=7, macro off → busy for 32 cycles, out_valid at cycle 33, result 0xFFFFFFEB. Macro on → same result at cycle 1.
3. DIV -7/2 → 0xFFFFFFFD; REM -7,2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100,7 → 2. Each with out_valid at cycle 33.
4. DIV 10/0 → 0xFFFFFFFF; REM 10,0 → 10; DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM same operands → 0. All with 1-cycle latency.
5. BGEU r1=r2=3 → 1. Hold out_ready=0 for 5 cycles → result and out_valid stable, in_ready=0, a pulsed in_valid is ignored. out_ready=1 → in_ready=1 next cycle.
6. flush in cycle 10 of a DIV → out_valid never asserts, in_ready=1 next cycle. rst_n low mid-MUL → out_valid=0, busy=0, result=0 with no clock edge required.
